// File: rtl/cdc_multi_pulse_sync_pkg.sv
// Shared constants and helpers for the multi-channel pulse synchroniser.
// Edge-mode encodings and the filter-counter width helper.
package cdc_multi_pulse_sync_pkg;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_BOTH    = 2;

  // Filter counter must hold 0..filter_len; never narrower than one bit.
  function automatic int unsigned filt_cnt_w(input int unsigned filter_len);
    return (filter_len == 0) ? 1 : $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/cdc_multi_pulse_sync_if.sv
// Bus bundle for cdc_multi_pulse_sync.
// async_in/cnt_clr flow into the block; pulse_out, level_out, event_cnt
// (and ovf when CDC_MULTI_PULSE_SYNC_OVF_EN is defined) flow out.
interface cdc_multi_pulse_sync_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 8
);

  logic [CHANNELS-1:0]           async_in;
  logic [CHANNELS-1:0]           cnt_clr;
  logic [CHANNELS-1:0]           pulse_out;
  logic [CHANNELS-1:0]           level_out;
  logic [CHANNELS*CNT_WIDTH-1:0] event_cnt;
`ifdef CDC_MULTI_PULSE_SYNC_OVF_EN
  logic [CHANNELS-1:0]           ovf;

  modport master (output async_in, cnt_clr,
                  input  pulse_out, level_out, event_cnt, ovf);
  modport slave  (input  async_in, cnt_clr,
                  output pulse_out, level_out, event_cnt, ovf);
`else
  modport master (output async_in, cnt_clr,
                  input  pulse_out, level_out, event_cnt);
  modport slave  (input  async_in, cnt_clr,
                  output pulse_out, level_out, event_cnt);
`endif

endinterface

// File: rtl/cdc_multi_pulse_sync_chan.sv
// One channel: synchroniser chain, optional glitch filter, edge detector,
// saturating event counter and (with CDC_MULTI_PULSE_SYNC_OVF_EN) sticky overflow.
// Ports: clk_in, rst_n (sync, active low), async_in, cnt_clr,
//        pulse_out, level_out, event_cnt[CNT_WIDTH], ovf (optional).
module cdc_multi_pulse_sync_chan
  import cdc_multi_pulse_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 0,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 async_in,
  input  logic                 cnt_clr,
  output logic                 pulse_out,
  output logic                 level_out,
`ifdef CDC_MULTI_PULSE_SYNC_OVF_EN
  output logic                 ovf,
`endif
  output logic [CNT_WIDTH-1:0] event_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level_d;
  logic                   edge_c;

  // Plain shift chain, no logic between stages.
  always_ff @(posedge clk_in) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_LEN == 0) begin : g_nofilt
      always_ff @(posedge clk_in) begin
        if (!rst_n) level_out <= 1'b0;
        else        level_out <= sync;
      end
    end else begin : g_filt
      localparam int unsigned FCW = filt_cnt_w(FILTER_LEN);
      logic [FCW-1:0] filt_cnt;

      // New level is accepted after FILTER_LEN+1 consecutive disagreeing
      // samples, i.e. FILTER_LEN cycles beyond the bypass path.
      always_ff @(posedge clk_in) begin
        if (!rst_n) begin
          filt_cnt  <= '0;
          level_out <= 1'b0;
        end else if (sync == level_out) begin
          filt_cnt  <= '0;
        end else if (filt_cnt == FCW'(FILTER_LEN)) begin
          filt_cnt  <= '0;
          level_out <= sync;
        end else begin
          filt_cnt  <= filt_cnt + FCW'(1);
        end
      end
    end
  endgenerate

  // Edge selection on the filtered level.
  always_comb begin
    edge_c = 1'b0;
    if (EDGE_MODE == EDGE_RISING)       edge_c = level_out & ~level_d;
    else if (EDGE_MODE == EDGE_FALLING) edge_c = ~level_out & level_d;
    else                                edge_c = level_out ^ level_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      level_d   <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      level_d   <= level_out;
      pulse_out <= edge_c;
    end
  end

  // A clear coinciding with a pulse keeps that event.
  always_ff @(posedge clk_in) begin
    if (!rst_n)                               event_cnt <= '0;
    else if (cnt_clr)                         event_cnt <= CNT_WIDTH'(pulse_out);
    else if (pulse_out && event_cnt != CNT_MAX) event_cnt <= event_cnt + CNT_WIDTH'(1);
  end

`ifdef CDC_MULTI_PULSE_SYNC_OVF_EN
  // Sticky overflow; clear wins over a simultaneous overflow.
  always_ff @(posedge clk_in) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (cnt_clr) ovf <= 1'b0;
    else if (pulse_out && event_cnt == CNT_MAX) ovf <= 1'b1;
  end
`endif

endmodule

// File: rtl/cdc_multi_pulse_sync.sv
// Multi-channel asynchronous-input synchroniser and event detector.
// Ports: clk_in, rst_n (sync, active low), bus (cdc_multi_pulse_sync_if.slave:
//        async_in, cnt_clr in; pulse_out, level_out, event_cnt out).
// Optional macro CDC_MULTI_PULSE_SYNC_OVF_EN adds bus.ovf sticky overflow flags.
module cdc_multi_pulse_sync
  import cdc_multi_pulse_sync_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 0,
  parameter int unsigned EDGE_MODE   = EDGE_RISING,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input logic                   clk_in,
  input logic                   rst_n,
  cdc_multi_pulse_sync_if.slave bus
);

  logic [CHANNELS-1:0]           pulse_v;
  logic [CHANNELS-1:0]           level_v;
  logic [CHANNELS*CNT_WIDTH-1:0] cnt_v;
`ifdef CDC_MULTI_PULSE_SYNC_OVF_EN
  logic [CHANNELS-1:0]           ovf_v;
  assign bus.ovf = ovf_v;
`endif

  // Independent channel instances.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    cdc_multi_pulse_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .EDGE_MODE   (EDGE_MODE),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_chan (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .async_in  (bus.async_in[i]),
      .cnt_clr   (bus.cnt_clr[i]),
      .pulse_out (pulse_v[i]),
      .level_out (level_v[i]),
`ifdef CDC_MULTI_PULSE_SYNC_OVF_EN
      .ovf       (ovf_v[i]),
`endif
      .event_cnt (cnt_v[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  assign bus.pulse_out = pulse_v;
  assign bus.level_out = level_v;
  assign bus.event_cnt = cnt_v;

endmodule

// File: tb/tb_cdc_multi_pulse_sync.sv
// Bench: three configurations driven by the same stimulus and checked each
// cycle against a history-based reference model, plus directed checks.
// A: S=2 F=0 rising CW=8; B: S=2 F=4 both CW=3; C: S=3 F=1 falling CW=4.
module tb_cdc_multi_pulse_sync;

  localparam int MAXT = 4096;
  localparam int S_M  [3] = '{2, 2, 3};
  localparam int F_M  [3] = '{0, 4, 1};
  localparam int MD_M [3] = '{0, 2, 1};
  localparam int CW_M [3] = '{8, 3, 4};

  logic       clk_in;
  logic       rst_n;
  logic [3:0] async_v;
  logic [3:0] clr_v;

  int n_assert = 0;
  int n_fail   = 0;
  int t        = 0;

  bit [3:0]    in_h  [MAXT];
  bit [3:0]    clr_h [MAXT];
  bit          rst_h [MAXT];
  bit [3:0]    syn_h [3][MAXT];
  bit [3:0]    lvl_h [3][MAXT];
  bit [3:0]    pul_h [3][MAXT];
  bit [3:0]    ovf_h [3][MAXT];
  int unsigned cnt_h [3][MAXT][4];

  cdc_multi_pulse_sync_if #(.CHANNELS(4), .CNT_WIDTH(8)) if_a ();
  cdc_multi_pulse_sync_if #(.CHANNELS(4), .CNT_WIDTH(3)) if_b ();
  cdc_multi_pulse_sync_if #(.CHANNELS(4), .CNT_WIDTH(4)) if_c ();

  assign if_a.async_in = async_v;
  assign if_b.async_in = async_v;
  assign if_c.async_in = async_v;
  assign if_a.cnt_clr  = clr_v;
  assign if_b.cnt_clr  = clr_v;
  assign if_c.cnt_clr  = clr_v;

  cdc_multi_pulse_sync #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(0),
    .EDGE_MODE(0), .CNT_WIDTH(8)) u_a (.clk_in(clk_in), .rst_n(rst_n), .bus(if_a));
  cdc_multi_pulse_sync #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(4),
    .EDGE_MODE(2), .CNT_WIDTH(3)) u_b (.clk_in(clk_in), .rst_n(rst_n), .bus(if_b));
  cdc_multi_pulse_sync #(.CHANNELS(4), .SYNC_STAGES(3), .FILTER_LEN(1),
    .EDGE_MODE(1), .CNT_WIDTH(4)) u_c (.clk_in(clk_in), .rst_n(rst_n), .bus(if_c));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected state after edge tt, from input history.
  // sync = input delayed S edges (zeroed by reset); level flips once sync
  // has disagreed with it for F+1 consecutive samples.
  function automatic void model_step(int tt);
    for (int m = 0; m < 3; m++) begin
      bit [3:0] syn, lvl, pul, ovf, prev, lv2, rise, fall;
      bit ok, flip, pp;
      int unsigned mx, c;
      ok = 1'b1;
      for (int k = 0; k < S_M[m]; k++)
        if (tt - k < 0) ok = 1'b0;
        else if (rst_h[tt-k]) ok = 1'b0;
      syn = 4'h0;
      if (ok) syn = in_h[tt-S_M[m]+1];
      syn_h[m][tt] = syn;
      mx = (1 << CW_M[m]) - 1;
      if (rst_h[tt] || tt == 0) begin
        lvl_h[m][tt] = 4'h0;
        pul_h[m][tt] = 4'h0;
        ovf_h[m][tt] = 4'h0;
        for (int i = 0; i < 4; i++) cnt_h[m][tt][i] = 0;
      end else begin
        prev = lvl_h[m][tt-1];
        for (int i = 0; i < 4; i++) begin
          flip = 1'b1;
          for (int k = 0; k <= F_M[m]; k++)
            if (tt - 1 - k < 0) flip = 1'b0;
            else if (syn_h[m][tt-1-k][i] == prev[i]) flip = 1'b0;
          lvl[i] = flip ? ~prev[i] : prev[i];
        end
        lv2 = 4'h0;
        if (tt >= 2 && !rst_h[tt-1]) lv2 = lvl_h[m][tt-2];
        rise = prev & ~lv2;
        fall = ~prev & lv2;
        pul  = (MD_M[m] == 0) ? rise : (MD_M[m] == 1) ? fall : (rise | fall);
        ovf  = ovf_h[m][tt-1];
        for (int i = 0; i < 4; i++) begin
          pp = pul_h[m][tt-1][i];
          c  = cnt_h[m][tt-1][i];
          if (clr_h[tt][i]) begin
            cnt_h[m][tt][i] = pp ? 1 : 0;
            ovf[i] = 1'b0;
          end else begin
            if (pp && c == mx) ovf[i] = 1'b1;
            cnt_h[m][tt][i] = (pp && c < mx) ? c + 1 : c;
          end
        end
        lvl_h[m][tt] = lvl;
        pul_h[m][tt] = pul;
        ovf_h[m][tt] = ovf;
      end
    end
  endfunction

  function automatic logic [31:0] exp_cnt(int m, int tt);
    logic [31:0] e;
    e = 32'h0;
    for (int i = 0; i < 4; i++) e = e | (32'(cnt_h[m][tt][i]) << (i * CW_M[m]));
    return e;
  endfunction

  task automatic check_all(int tt);
    chk("a_pulse", 32'(if_a.pulse_out), 32'(pul_h[0][tt]));
    chk("a_level", 32'(if_a.level_out), 32'(lvl_h[0][tt]));
    chk("a_cnt",   32'(if_a.event_cnt), exp_cnt(0, tt));
    chk("b_pulse", 32'(if_b.pulse_out), 32'(pul_h[1][tt]));
    chk("b_level", 32'(if_b.level_out), 32'(lvl_h[1][tt]));
    chk("b_cnt",   32'(if_b.event_cnt), exp_cnt(1, tt));
    chk("c_pulse", 32'(if_c.pulse_out), 32'(pul_h[2][tt]));
    chk("c_level", 32'(if_c.level_out), 32'(lvl_h[2][tt]));
    chk("c_cnt",   32'(if_c.event_cnt), exp_cnt(2, tt));
`ifdef CDC_MULTI_PULSE_SYNC_OVF_EN
    chk("a_ovf", 32'(if_a.ovf), 32'(ovf_h[0][tt]));
    chk("b_ovf", 32'(if_b.ovf), 32'(ovf_h[1][tt]));
    chk("c_ovf", 32'(if_c.ovf), 32'(ovf_h[2][tt]));
`endif
  endtask

  // One clock: drive at the falling edge, model the rising edge, check after.
  task automatic step(input bit r, input bit [3:0] a, input bit [3:0] c);
    if (t >= MAXT) begin
      $display("FAIL cycle_budget: observed %0d cycles, limit %0d", t, MAXT);
      $fatal(1, "cycle budget exhausted");
    end
    rst_n   = ~r;
    async_v = a;
    clr_v   = c;
    in_h[t]  = a;
    clr_h[t] = c;
    rst_h[t] = r;
    @(posedge clk_in);
    model_step(t);
    @(negedge clk_in);
    check_all(t);
    t++;
  endtask

  initial begin
    int       hold [4];
    bit [3:0] cur;
    bit       seen;

    // Reset state
    repeat (3) step(1'b1, 4'h0, 4'h0);
    chk("rst_a_pulse", 32'(if_a.pulse_out), 32'h0);
    chk("rst_b_level", 32'(if_b.level_out), 32'h0);
    chk("rst_b_cnt",   32'(if_b.event_cnt), 32'h0);

    // Latency: ch0 rises; A pulses after edge 3, B after edge 7
    for (int e = 0; e < 9; e++) begin
      step(1'b0, 4'b0001, 4'h0);
      if (e == 2) chk("lat_a_level", 32'(if_a.level_out), 32'h1);
      if (e == 2) chk("lat_a_nopulse", 32'(if_a.pulse_out), 32'h0);
      if (e == 3) chk("lat_a_pulse", 32'(if_a.pulse_out), 32'h1);
      if (e == 4) chk("lat_a_pulse_end", 32'(if_a.pulse_out), 32'h0);
      if (e == 4) chk("lat_a_cnt", 32'(if_a.event_cnt), 32'h1);
      if (e == 6) chk("lat_b_level", 32'(if_b.level_out), 32'h1);
      if (e == 7) chk("lat_b_pulse", 32'(if_b.pulse_out), 32'h1);
    end

    // Glitch: ch1 high for 3 cycles never reaches B's level
    for (int e = 0; e < 15; e++) begin
      step(1'b0, (e < 3) ? 4'b0011 : 4'b0001, 4'h0);
      chk("glitch_b_level", 32'(if_b.level_out), 32'h1);
      chk("glitch_b_pulse", 32'(if_b.pulse_out[1]), 32'h0);
    end

    // ch1 high for 6 cycles: rise pulse after edge 7, fall pulse after edge 13
    for (int e = 0; e < 16; e++) begin
      step(1'b0, (e < 6) ? 4'b0011 : 4'b0001, 4'h0);
      if (e == 6)  chk("filt_b_level_up", 32'(if_b.level_out), 32'h3);
      if (e == 7)  chk("filt_b_rise", 32'(if_b.pulse_out), 32'h2);
      if (e == 12) chk("filt_b_level_dn", 32'(if_b.level_out), 32'h1);
      if (e == 13) chk("filt_b_fall", 32'(if_b.pulse_out), 32'h2);
    end

    // Saturation: 9 high pulses on ch2
    for (int p = 0; p < 9; p++)
      for (int e = 0; e < 16; e++) step(1'b0, (e < 8) ? 4'b0101 : 4'b0001, 4'h0);
    repeat (10) step(1'b0, 4'b0001, 4'h0);
    chk("sat_a_cnt2", 32'(if_a.event_cnt[23:16]), 32'd9);
    chk("sat_b_cnt2", 32'(if_b.event_cnt[8:6]), 32'd7);
    chk("sat_c_cnt2", 32'(if_c.event_cnt[11:8]), 32'd9);
`ifdef CDC_MULTI_PULSE_SYNC_OVF_EN
    chk("sat_b_ovf2", 32'(if_b.ovf[2]), 32'h1);
`endif
    step(1'b0, 4'b0001, 4'b0100);
    chk("clr_b_cnt2", 32'(if_b.event_cnt[8:6]), 32'd0);
`ifdef CDC_MULTI_PULSE_SYNC_OVF_EN
    chk("clr_b_ovf2", 32'(if_b.ovf[2]), 32'h0);
`endif

    // Clear/event collision on ch3 of A
    seen = 1'b0;
    for (int e = 0; e < 10 && !seen; e++) begin
      step(1'b0, 4'b1001, 4'h0);
      seen = if_a.pulse_out[3];
    end
    chk("coll_wait_pulse", 32'(seen), 32'h1);
    step(1'b0, 4'b1001, 4'b1000);
    chk("coll_a_cnt3", 32'(if_a.event_cnt[31:24]), 32'd1);

    // Reset mid-filter: ch0 low, then high for 4 edges, reset with input high
    repeat (20) step(1'b0, 4'b1000, 4'h0);
    repeat (4) step(1'b0, 4'b1001, 4'h0);
    repeat (3) step(1'b1, 4'b1001, 4'h0);
    chk("mid_rst_a_level", 32'(if_a.level_out), 32'h0);
    chk("mid_rst_b_level", 32'(if_b.level_out), 32'h0);
    chk("mid_rst_b_pulse", 32'(if_b.pulse_out), 32'h0);
    chk("mid_rst_a_cnt",   32'(if_a.event_cnt), 32'h0);
    for (int e = 0; e < 9; e++) begin
      step(1'b0, 4'b1001, 4'h0);
      if (e == 3) chk("rel_a_pulse", 32'(if_a.pulse_out), 32'h9);
      if (e == 7) chk("rel_b_pulse", 32'(if_b.pulse_out), 32'h9);
      if (e == 8) chk("rel_a_cnt", 32'(if_a.event_cnt), 32'h0100_0001);
      if (e == 8) chk("rel_b_cnt", 32'(if_b.event_cnt), 32'h201);
    end

    // Simultaneous toggle of every channel
    for (int e = 0; e < 9; e++) begin
      step(1'b0, 4'b0110, 4'h0);
      if (e == 3) chk("sim_a_pulse", 32'(if_a.pulse_out), 32'h6);
      if (e == 7) chk("sim_b_pulse1", 32'(if_b.pulse_out), 32'hF);
    end
    for (int e = 0; e < 9; e++) begin
      step(1'b0, 4'b1001, 4'h0);
      if (e == 7) chk("sim_b_pulse2", 32'(if_b.pulse_out), 32'hF);
    end

    // Random hold lengths, sparse clears and occasional reset
    cur = async_v;
    for (int i = 0; i < 4; i++) hold[i] = int'($urandom_range(10, 1));
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++)
        if (hold[i] == 0) begin
          cur[i]  = ~cur[i];
          hold[i] = int'($urandom_range(10, 1));
        end else begin
          hold[i]--;
        end
      step($urandom_range(299, 0) == 0, cur,
           4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
